// File: rtl/fifo_word_packer.sv
// Packs show-ahead FIFO entries into lanes-wide words, lane 0 first, with flush of partial words.
// Optional out_parity output enabled by defining PACKER_PARITY_EN.
module fifo_word_packer #(
   parameter int bits  = 8,
   parameter int lanes = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fifo_empty,
   input  logic [bits-1:0]         fifo_dout,
   output logic                    fifo_pop,
   input  logic                    flush,
   output logic [bits*lanes-1:0]   out_data,
   output logic [lanes-1:0]        out_keep,
   output logic                    out_valid,
`ifdef PACKER_PARITY_EN
   output logic                    out_parity,
`endif
   input  logic                    out_ready
);

   localparam int CW = $clog2(lanes + 1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
   logic [bits*lanes-1:0]   data_q, data_d;
   logic [lanes-1:0]        keep_q, keep_d;
   logic                    parity_q;

   function automatic logic [lanes-1:0] keep_mask(input logic [CW-1:0] n);
      keep_mask = '0;
      for (int i = 0; i < lanes; i++) begin
         keep_mask[i] = (CW'(i) < n);
      end
   endfunction

   always_comb begin
      fifo_pop = 1'b0;
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      keep_d   = keep_q;
      cnt_inc  = cnt_q + CW'(1);
      if (!rst) begin
         case (state_q)
            FILL: begin
               fifo_pop = !fifo_empty;
               if (fifo_pop) begin
                  for (int i = 0; i < lanes; i++) begin
                     if (CW'(i) == cnt_q) data_d[i*bits +: bits] = fifo_dout;
                  end
                  cnt_d = cnt_inc;
                  // A pop that completes the word or coincides with flush closes it, popped entry included.
                  if (cnt_inc == CW'(lanes) || flush) begin
                     state_d = HOLD;
                     keep_d  = keep_mask(cnt_inc);
                     cnt_d   = '0;
                  end
               end else if (flush && cnt_q != '0) begin
                  state_d = HOLD;
                  keep_d  = keep_mask(cnt_q);
                  cnt_d   = '0;
               end
            end
            HOLD: begin
               fifo_pop = !fifo_empty && out_ready;
               if (out_ready) begin
                  state_d = FILL;
                  keep_d  = '0;
                  data_d  = '0;
                  cnt_d   = '0;
                  // Entry popped during the transfer starts the next word.
                  if (fifo_pop) begin
                     data_d[bits-1:0] = fifo_dout;
                     cnt_d            = CW'(1);
                  end
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FILL;
         cnt_q    <= '0;
         data_q   <= '0;
         keep_q   <= '0;
         parity_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         keep_q   <= keep_d;
         parity_q <= ^data_d;
      end
   end

   assign out_data  = data_q;
   assign out_keep  = keep_q;
   assign out_valid = (state_q == HOLD);
`ifdef PACKER_PARITY_EN
   assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Randomized bench for fifo_word_packer against a queue-based word-collection model.
module tb_fifo_word_packer;
   localparam int BITS  = 8;
   localparam int LANES = 4;

   logic        clk = 1'b0;
   logic        rst, fifo_empty, flush, out_ready, fifo_pop, out_valid;
   logic [7:0]  fifo_dout;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
`ifdef PACKER_PARITY_EN
   logic        out_parity;
`endif

   always #5 clk = ~clk;

   fifo_word_packer #(.bits(BITS), .lanes(LANES)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_pop(fifo_pop), .flush(flush), .out_data(out_data), .out_keep(out_keep),
      .out_valid(out_valid),
`ifdef PACKER_PARITY_EN
      .out_parity(out_parity),
`endif
      .out_ready(out_ready)
   );

   logic [7:0]  fifo_q[$];
   logic [7:0]  pending[$];
   logic [7:0]  m_word[$];
   logic        m_hold;
   logic [31:0] xfer_data[$];
   logic [3:0]  xfer_keep[$];
   int          xfer_cyc[$];
   int          n_pass = 0, n_chk = 0, cyc = 0, pops = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [31:0] pack(input logic [7:0] q[$]);
      pack = '0;
      for (int i = 0; i < q.size(); i++) pack = pack | (32'(q[i]) << (8 * i));
   endfunction

   function automatic logic [3:0] mask(input int n);
      mask = 4'((1 << n) - 1);
   endfunction

   task automatic drive_fifo();
      fifo_empty = (fifo_q.size() == 0);
      fifo_dout  = fifo_empty ? 8'hEE : fifo_q[0];
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      drive_fifo();
   endtask

   task automatic clear_log();
      xfer_data.delete(); xfer_keep.delete(); xfer_cyc.delete(); pops = 0;
   endtask

   task automatic cycle();
      logic       exp_pop, act_pop;
      logic [7:0] head;
      @(negedge clk);
      exp_pop = !rst && (fifo_q.size() > 0) && (!m_hold || out_ready);
      act_pop = fifo_pop;
      chk("pop", act_pop, exp_pop);
      chk("valid", out_valid, m_hold);
      if (m_hold) begin
         chk("data", out_data, pack(m_word));
         chk("keep", out_keep, mask(m_word.size()));
`ifdef PACKER_PARITY_EN
         chk("parity", out_parity, ^pack(m_word));
`endif
      end
      head = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      if (rst) begin
         m_hold = 1'b0;
         pending.delete();
      end else if (m_hold) begin
         if (out_ready) begin
            xfer_data.push_back(pack(m_word));
            xfer_keep.push_back(mask(m_word.size()));
            xfer_cyc.push_back(cyc);
            m_hold = 1'b0;
            pending.delete();
            if (exp_pop) pending.push_back(head);
         end
      end else begin
         if (exp_pop) pending.push_back(head);
         if (pending.size() == LANES || (flush && pending.size() > 0)) begin
            m_word = pending;
            m_hold = 1'b1;
            pending.delete();
         end
      end
      @(posedge clk);
      #1;
      if (act_pop && fifo_q.size() > 0) begin
         void'(fifo_q.pop_front());
         pops++;
      end
      cyc++;
      drive_fifo();
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   initial begin
      logic [31:0] w;
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0; m_hold = 1'b0;
      push(8'h55);
      run(3);
      chk("rst_data", out_data, 32'h0);
      chk("rst_keep", out_keep, 4'h0);
      chk("rst_nopop", pops, 0);
      rst = 1'b0;
      fifo_q.delete();
      drive_fifo();

      // four entries, ready downstream
      clear_log();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) push(8'(i));
      run(8);
      chk("s29_nword", xfer_data.size(), 1);
      chk("s29_data", xfer_data[0], 32'h04030201);
      chk("s29_keep", xfer_keep[0], 4'hF);
      chk("s29_pops", pops, 4);

      // partial word closed by flush
      clear_log();
      out_ready = 1'b0;
      push(8'h0A); push(8'h0B);
      run(3);
      flush = 1'b1; run(1); flush = 1'b0;
      run(2);
      out_ready = 1'b1; run(3);
      chk("s30_nword", xfer_data.size(), 1);
      chk("s30_data", xfer_data[0], 32'h00000B0A);
      chk("s30_keep", xfer_keep[0], 4'h3);
      chk("s30_empty", fifo_q.size(), 0);

      // backpressure with 16 queued entries
      clear_log();
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
      run(10);
      chk("s31_count", fifo_q.size(), 12);
      chk("s31_pops", pops, 4);
      out_ready = 1'b1;
      run(20);
      chk("s31_nword", xfer_data.size(), 4);
      chk("s31_first", xfer_data[0], 32'h13121110);

      // continuous stream
      clear_log();
      for (int i = 0; i < 16; i++) push(8'(i));
      run(22);
      chk("s32_nword", xfer_data.size(), 4);
      for (int k = 0; k < 4; k++) begin
         w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
         chk("s32_data", xfer_data[k], w);
         if (k > 0) chk("s32_rate", xfer_cyc[k] - xfer_cyc[k-1], 4);
      end

      // reset mid-word
      clear_log();
      push(8'hA1); push(8'hA2);
      run(2);
      rst = 1'b1; run(1);
      chk("s33_valid", out_valid, 1'b0);
      chk("s33_keep", out_keep, 4'h0);
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) push(8'(8'hB0 + i));
      run(8);
      chk("s33_nword", xfer_data.size(), 1);
      chk("s33_data", xfer_data[0], 32'hB4B3B2B1);
      chk("s33_keep2", xfer_keep[0], 4'hF);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         rst       = ($urandom_range(0, 99) == 0);
         flush     = ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) push(8'($urandom));
         cycle();
      end
      rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
      run(30);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
